// File: rtl/cv32e40p_x_resp_pkg.sv
// rtl/cv32e40p_x_resp_pkg.sv - shared types and constants for the X-interface responder
package cv32e40p_x_resp_pkg;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

    typedef enum logic [1:0] {
        OP_ADD3 = 2'd0,
        OP_MAXS = 2'd1,
        OP_POPC = 2'd2
    } x_resp_op_e;

    typedef struct packed {
        logic [3:0]  id;
        x_resp_op_e  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] rs3;
        logic [4:0]  rd;
        logic        committed;
        logic        killed;
    } x_resp_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } x_resp_state_e;

endpackage

// File: rtl/cv32e40p_x_resp_alu.sv
// rtl/cv32e40p_x_resp_alu.sv - combinational datapath for the custom-0 operations
module cv32e40p_x_resp_alu
    import cv32e40p_x_resp_pkg::*;
(
    input  x_resp_op_e  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] rs3,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD3: result = rs1 + rs2 + rs3;
            OP_MAXS: result = ($signed(rs1) > $signed(rs2)) ? rs1 : rs2;
            OP_POPC: begin
                for (int i = 0; i < 32; i++) begin
                    result = result + 32'(rs1[i]);
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/cv32e40p_x_resp.sv
// rtl/cv32e40p_x_resp.sv - coprocessor responder: issue decode, in-order buffer, execute, result
module cv32e40p_x_resp
    import cv32e40p_x_resp_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter int unsigned Latency = 2,
    parameter bit          KillEn  = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             x_issue_valid_i,
    output logic             x_issue_ready_o,
    input  logic [31:0]      x_issue_req_instr_i,
    input  logic [3:0]       x_issue_req_id_i,
    input  logic [2:0][31:0] x_issue_req_rs_i,
    input  logic [2:0]       x_issue_req_rs_valid_i,
    output logic             x_issue_resp_accept_o,
    output logic             x_issue_resp_writeback_o,
    output logic             x_issue_resp_loadstore_o,
    input  logic             x_commit_valid_i,
    input  logic [3:0]       x_commit_id_i,
    input  logic             x_commit_commit_kill_i,
    output logic             x_result_valid_o,
    input  logic             x_result_ready_i,
    output logic [3:0]       x_result_id_o,
    output logic [31:0]      x_result_data_o,
    output logic [4:0]       x_result_rd_o,
    output logic             x_result_we_o,
    output logic             busy_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;
    localparam logic [3:0] LAT_LOAD = 4'(Latency - 1);

    logic            legal;
    x_resp_op_e      dec_op;
    logic [2:0]      need;
    logic            push;
    logic            pop;
    logic            commit_new;
    x_resp_entry_t   new_ent;
    x_resp_entry_t   entries [Depth];
    logic [Depth-1:0] ent_valid;
    logic [PtrW-1:0] head;
    logic [PtrW-1:0] tail;
    logic [CntW-1:0] count;
    x_resp_entry_t   head_ent;
    logic            head_valid;
    x_resp_state_e   state;
    x_resp_state_e   state_next;
    logic [3:0]      cnt;
    logic [3:0]      cnt_next;
    logic            load_res;
    logic [31:0]     alu_result;
    logic            unused_instr;

    assign unused_instr = ^x_issue_req_instr_i[31:15];

    always_comb begin
        legal  = 1'b0;
        dec_op = OP_ADD3;
        need   = 3'b000;
        if (x_issue_req_instr_i[6:0] == OPCODE_CUSTOM0) begin
            case (x_issue_req_instr_i[14:12])
                3'b000: begin legal = 1'b1; dec_op = OP_ADD3; need = 3'b111; end
                3'b001: begin legal = 1'b1; dec_op = OP_MAXS; need = 3'b011; end
                3'b010: begin legal = 1'b1; dec_op = OP_POPC; need = 3'b001; end
                default: legal = 1'b0;
            endcase
        end
    end

    // Illegal instructions are always ready so the dispatcher sees an immediate reject.
    assign x_issue_ready_o = !legal ||
        ((count < CntW'(Depth)) && ((x_issue_req_rs_valid_i & need) == need));
    assign x_issue_resp_accept_o    = legal;
    assign x_issue_resp_writeback_o = legal;
    assign x_issue_resp_loadstore_o = 1'b0;
    assign push = x_issue_valid_i && x_issue_ready_o && legal;

    assign commit_new = x_commit_valid_i && (x_commit_id_i == x_issue_req_id_i);

    always_comb begin
        new_ent.id        = x_issue_req_id_i;
        new_ent.op        = dec_op;
        new_ent.rs1       = x_issue_req_rs_i[0];
        new_ent.rs2       = x_issue_req_rs_i[1];
        new_ent.rs3       = x_issue_req_rs_i[2];
        new_ent.rd        = x_issue_req_instr_i[11:7];
        new_ent.committed = commit_new;
        new_ent.killed    = commit_new && KillEn && x_commit_commit_kill_i;
    end

    assign head_ent   = entries[head];
    assign head_valid = ent_valid[head];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            entries   <= '{default: '0};
            ent_valid <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (x_commit_valid_i && ent_valid[i] && (entries[i].id == x_commit_id_i)) begin
                    entries[i].committed <= 1'b1;
                    if (KillEn && x_commit_commit_kill_i) begin
                        entries[i].killed <= 1'b1;
                    end
                end
            end
            if (push) begin
                entries[tail]   <= new_ent;
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PtrW'(1);
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PtrW'(1);
            end
            if (push && !pop) begin
                count <= count + CntW'(1);
            end else if (pop && !push) begin
                count <= count - CntW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        load_res   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (head_valid && head_ent.killed) begin
                    pop = 1'b1;
                end else if (head_valid && head_ent.committed) begin
                    if (Latency <= 1) begin
                        load_res   = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        cnt_next   = LAT_LOAD;
                        state_next = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    load_res   = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (x_result_ready_i) begin
                    pop        = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    cv32e40p_x_resp_alu u_alu (
        .op     (head_ent.op),
        .rs1    (head_ent.rs1),
        .rs2    (head_ent.rs2),
        .rs3    (head_ent.rs3),
        .result (alu_result)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            x_result_id_o   <= '0;
            x_result_data_o <= '0;
            x_result_rd_o   <= '0;
            x_result_we_o   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load_res) begin
                x_result_id_o   <= head_ent.id;
                x_result_data_o <= alu_result;
                x_result_rd_o   <= head_ent.rd;
                x_result_we_o   <= 1'b1;
            end
        end
    end

    assign x_result_valid_o = (state == ST_RESP);
    assign busy_o           = (count != '0) || (state == ST_RESP);

endmodule

// File: tb/tb_cv32e40p_x_resp.sv
// tb/tb_cv32e40p_x_resp.sv - scoreboard bench for the X-interface responder
module tb_cv32e40p_x_resp;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             issue_valid;
    logic             issue_ready;
    logic [31:0]      issue_instr;
    logic [3:0]       issue_id;
    logic [2:0][31:0] issue_rs;
    logic [2:0]       issue_rs_valid;
    logic             resp_accept;
    logic             resp_writeback;
    logic             resp_loadstore;
    logic             commit_valid;
    logic [3:0]       commit_id;
    logic             commit_kill;
    logic             result_valid;
    logic             result_ready;
    logic [3:0]       result_id;
    logic [31:0]      result_data;
    logic [4:0]       result_rd;
    logic             result_we;
    logic             busy;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cv32e40p_x_resp #(.Depth(4), .Latency(2), .KillEn(1'b1)) u_dut (
        .clk_i                    (clk),
        .rst_ni                   (rst_n),
        .x_issue_valid_i          (issue_valid),
        .x_issue_ready_o          (issue_ready),
        .x_issue_req_instr_i      (issue_instr),
        .x_issue_req_id_i         (issue_id),
        .x_issue_req_rs_i         (issue_rs),
        .x_issue_req_rs_valid_i   (issue_rs_valid),
        .x_issue_resp_accept_o    (resp_accept),
        .x_issue_resp_writeback_o (resp_writeback),
        .x_issue_resp_loadstore_o (resp_loadstore),
        .x_commit_valid_i         (commit_valid),
        .x_commit_id_i            (commit_id),
        .x_commit_commit_kill_i   (commit_kill),
        .x_result_valid_o         (result_valid),
        .x_result_ready_i         (result_ready),
        .x_result_id_o            (result_id),
        .x_result_data_o          (result_data),
        .x_result_rd_o            (result_rd),
        .x_result_we_o            (result_we),
        .busy_o                   (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
        return {7'h00, 5'd3, 5'd2, f3, rd, 7'b0001011};
    endfunction

    always @(negedge clk) begin
        if (result_valid && result_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual_id=%0d expected=none", result_id);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_id", 32'(result_id), 32'(e.id));
                chk("res_data", result_data, e.data);
                chk("res_rd", 32'(result_rd), 32'(e.rd));
                chk("res_we", 32'(result_we), 32'd1);
            end
        end
    end

    task automatic issue_start(input logic [31:0] instr, input logic [3:0] id,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                               input logic [2:0] rsv, input logic do_commit);
        issue_valid    = 1'b1;
        issue_instr    = instr;
        issue_id       = id;
        issue_rs[0]    = a;
        issue_rs[1]    = b;
        issue_rs[2]    = c;
        issue_rs_valid = rsv;
        commit_valid   = do_commit;
        commit_id      = id;
        commit_kill    = 1'b0;
    endtask

    task automatic issue_finish(input logic exp_acc, input logic exp_res,
                                input logic [31:0] exp_data, input logic [4:0] rd);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!issue_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", 32'(issue_ready), 32'd1);
        chk("issue_accept", 32'(resp_accept), 32'(exp_acc));
        chk("issue_writeback", 32'(resp_writeback), 32'(exp_acc));
        chk("issue_loadstore", 32'(resp_loadstore), 32'd0);
        if (exp_res) begin
            e.id = issue_id;
            e.data = exp_data;
            e.rd = rd;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [3:0] id,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic do_commit, input logic exp_acc, input logic exp_res,
                         input logic [31:0] exp_data);
        issue_start(instr, id, a, b, c, 3'b111, do_commit);
        issue_finish(exp_acc, exp_res, exp_data, instr[11:7]);
    endtask

    task automatic commit(input logic [3:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n          = 1'b0;
        issue_valid    = 1'b0;
        issue_instr    = '0;
        issue_id       = '0;
        issue_rs       = '0;
        issue_rs_valid = '0;
        commit_valid   = 1'b0;
        commit_id      = '0;
        commit_kill    = 1'b0;
        result_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_we", 32'(result_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", result_data, 32'd0);
        chk("rst_id_rd", {23'd0, result_id, result_rd}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADD3 with commit in the issue cycle; result two cycles after head is committed
        issue(mk(3'b000, 5'd5), 4'd3, 32'd1, 32'd2, 32'd3, 1'b1, 1'b1, 1'b1, 32'd6);
        @(negedge clk);
        chk("lat_c0_valid", 32'(result_valid), 32'd0);
        chk("lat_c0_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("lat_c1_valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        chk("lat_c2_valid", 32'(result_valid), 32'd1);
        @(posedge clk);
        #1;

        // Illegal opcode rejected; a commit for its id is ignored
        issue({7'h00, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011}, 4'd7, 32'd9, 32'd9, 32'd9,
              1'b0, 1'b0, 1'b0, 32'd0);
        commit(4'd7, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk("illegal_busy", 32'(busy), 32'd0);
            chk("illegal_valid", 32'(result_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Fill the buffer with POPC, fifth waits for the first pop
        issue(mk(3'b010, 5'd1), 4'd0, 32'hFFFF0000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd16);
        issue(mk(3'b010, 5'd2), 4'd1, 32'h00000001, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd1);
        issue(mk(3'b010, 5'd3), 4'd2, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd32);
        issue(mk(3'b010, 5'd4), 4'd3, 32'h00000000, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd0);
        issue_start(mk(3'b010, 5'd6), 4'd4, 32'h80000001, 32'd0, 32'd0, 3'b001, 1'b0);
        @(negedge clk);
        chk("full_ready0", 32'(issue_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("full_ready1", 32'(issue_ready), 32'd0);
        @(posedge clk);
        #1;
        commit_valid = 1'b1;
        commit_id    = 4'd0;
        @(negedge clk);
        chk("full_ready_commit", 32'(issue_ready), 32'd0);
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
        issue_finish(1'b1, 1'b1, 32'd2, 5'd6);
        for (int i = 1; i <= 4; i++) commit(4'(i), 1'b0);
        drain("popc_drain");

        // MAXS stalls until rs2 becomes valid
        issue_start(mk(3'b001, 5'd7), 4'd5, 32'hFFFFFFFF, 32'd5, 32'd0, 3'b001, 1'b1);
        commit_valid = 1'b0;
        @(negedge clk);
        chk("maxs_stall0", 32'(issue_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("maxs_stall1", 32'(issue_ready), 32'd0);
        @(posedge clk);
        #1;
        issue_rs_valid = 3'b011;
        commit_valid   = 1'b1;
        issue_finish(1'b1, 1'b1, 32'd5, 5'd7);
        issue(mk(3'b001, 5'd8), 4'd6, 32'h7FFFFFFF, 32'h80000000, 32'd0, 1'b1, 1'b1, 1'b1,
              32'h7FFFFFFF);
        drain("maxs_drain");

        // Back-pressure on the result channel
        result_ready = 1'b0;
        issue(mk(3'b000, 5'd10), 4'd8, 32'hFFFFFFFF, 32'd2, 32'd3, 1'b1, 1'b1, 1'b1, 32'd4);
        issue(mk(3'b000, 5'd11), 4'd9, 32'd10, 32'd20, 32'd30, 1'b1, 1'b1, 1'b1, 32'd60);
        n = 0;
        @(negedge clk);
        while (!result_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            chk("hold_valid", 32'(result_valid), 32'd1);
            chk("hold_id", 32'(result_id), 32'd8);
            chk("hold_data", result_data, 32'd4);
            chk("hold_rd", 32'(result_rd), 32'd10);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        result_ready = 1'b1;
        drain("hold_drain");

        // Killed head is dropped, committed entry behind it still completes
        issue(mk(3'b000, 5'd12), 4'd1, 32'd1, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0, 32'd0);
        issue(mk(3'b000, 5'd13), 4'd2, 32'd2, 32'd2, 32'd2, 1'b0, 1'b1, 1'b1, 32'd6);
        commit(4'd2, 1'b0);
        commit(4'd1, 1'b1);
        drain("kill_drain");
        repeat (3) @(negedge clk);
        chk("kill_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Synchronous reset while executing
        issue(mk(3'b000, 5'd14), 4'd5, 32'd7, 32'd7, 32'd7, 1'b1, 1'b1, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_exec_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        chk("rst_exec_valid", 32'(result_valid), 32'd0);
        chk("rst_exec_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(result_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        issue(mk(3'b000, 5'd15), 4'd11, 32'd100, 32'd200, 32'd300, 1'b1, 1'b1, 1'b1, 32'd600);
        drain("post_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
